// File: rtl/w_strb_serializer.sv
// Passive AXI W-beat snooper: queues strobed beats and emits enabled bytes one at a time, lowest lane first.
// Optional running signature compiled in with W_SERIALIZER_SIG_EN.
module w_strb_serializer #(
  parameter int DataWidth = 128,
  parameter int Depth     = 4
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic                     en_i,
  input  logic [DataWidth-1:0]     snoop_data_i,
  input  logic [DataWidth/8-1:0]   snoop_strb_i,
  input  logic                     snoop_valid_i,
  input  logic                     snoop_ready_i,
  output logic [7:0]               byte_o,
  output logic                     byte_valid_o,
  input  logic                     byte_ready_i,
  output logic [31:0]              byte_cnt_o,
  output logic                     overflow_o,
  output logic                     empty_o,
  output logic [31:0]              sig_o
);
  localparam int BeWidth = DataWidth / 8;
  localparam int PtrW    = $clog2(Depth);
  localparam int CntW    = PtrW + 1;
  localparam int EntW    = DataWidth + BeWidth;

  logic [EntW-1:0]      mem_q [Depth];
  logic [PtrW-1:0]      wptr_q, wptr_d, rptr_q, rptr_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [DataWidth-1:0] data_q, data_d;
  logic [BeWidth-1:0]   mask_q, mask_d;
  logic [31:0]          bcnt_q, bcnt_d;
  logic                 ovf_q, ovf_d;

  logic                 capture, push, pop, hs, full;
  logic [BeWidth-1:0]   low_bit, rest;
  logic [EntW-1:0]      head;
  logic [7:0]           byte_sel;

  assign capture = en_i & snoop_valid_i & snoop_ready_i & (|snoop_strb_i);
  // Isolate the lowest pending lane; the rest tells us if this is the beat's last byte.
  assign low_bit = mask_q & (~mask_q + {{(BeWidth-1){1'b0}}, 1'b1});
  assign rest    = mask_q & ~low_bit;
  assign hs      = byte_valid_o & byte_ready_i;
  assign full    = (cnt_q == CntW'(Depth));
  assign pop     = (cnt_q != '0) && ((mask_q == '0) || (hs && (rest == '0)));
  assign push    = capture && (!full || pop);
  assign head    = mem_q[rptr_q];

  // One-hot mux; yields 0 when no lane is pending so byte_o is clean after reset.
  always_comb begin
    byte_sel = '0;
    for (int i = 0; i < BeWidth; i++) begin
      if (low_bit[i]) byte_sel = data_q[i*8 +: 8];
    end
  end

  always_comb begin
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    data_d = data_q;
    mask_d = mask_q;
    bcnt_d = bcnt_q;
    ovf_d  = ovf_q | (capture & ~push);
    if (push) wptr_d = wptr_q + PtrW'(1);
    if (pop) begin
      rptr_d = rptr_q + PtrW'(1);
      data_d = head[EntW-1:BeWidth];
      mask_d = head[BeWidth-1:0];
    end else if (hs) begin
      mask_d = rest;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
    if (hs && (bcnt_q != 32'hFFFF_FFFF)) bcnt_d = bcnt_q + 32'd1;
  end

  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= {snoop_data_i, snoop_strb_i};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      data_q <= '0;
      mask_q <= '0;
      bcnt_q <= '0;
      ovf_q  <= 1'b0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      data_q <= data_d;
      mask_q <= mask_d;
      bcnt_q <= bcnt_d;
      ovf_q  <= ovf_d;
    end
  end

  assign byte_o       = byte_sel;
  assign byte_valid_o = (mask_q != '0);
  assign byte_cnt_o   = bcnt_q;
  assign overflow_o   = ovf_q;
  assign empty_o      = (cnt_q == '0) && (mask_q == '0);

`ifdef W_SERIALIZER_SIG_EN
  logic [31:0] sig_q, sig_d;

  always_comb begin
    sig_d = sig_q;
    if (hs) sig_d = {sig_q[30:0], sig_q[31]} ^ {24'b0, byte_o};
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) sig_q <= '0;
    else         sig_q <= sig_d;
  end

  assign sig_o = sig_q;
`else
  assign sig_o = '0;
`endif

endmodule

// File: tb/tb_w_strb_serializer.sv
// Directed bench for w_strb_serializer (DataWidth 128, Depth 4); expected values are hand-derived.
module tb_w_strb_serializer;
  logic         clk = 1'b0;
  logic         rst_n;
  logic         en;
  logic [127:0] sdata;
  logic [15:0]  sstrb;
  logic         svalid, sready;
  logic [7:0]   byte_o;
  logic         byte_valid, byte_ready;
  logic [31:0]  byte_cnt, sig;
  logic         ovf, empty;

  int n_vec = 0;
  int n_bad = 0;

  localparam logic [127:0] DATA_A = 128'h0F0E0D0C0B0A09080706050403020100;
  localparam logic [127:0] DATA_B = 128'h1F1E1D1C1B1A19181716151413121110;

  w_strb_serializer #(.DataWidth(128), .Depth(4)) dut (
    .clk_i(clk), .rst_ni(rst_n), .en_i(en),
    .snoop_data_i(sdata), .snoop_strb_i(sstrb),
    .snoop_valid_i(svalid), .snoop_ready_i(sready),
    .byte_o(byte_o), .byte_valid_o(byte_valid), .byte_ready_i(byte_ready),
    .byte_cnt_o(byte_cnt), .overflow_o(ovf), .empty_o(empty), .sig_o(sig)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic idle_bus();
    svalid = 1'b0;
    sstrb  = '0;
    sdata  = '0;
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b1; byte_ready = 1'b1;
    sready = 1'b1;
    idle_bus();
    tick(); tick();
    rst_n = 1'b1;

    // reset state
    chk("rst_valid", 32'(byte_valid), 32'd0);
    chk("rst_byte",  32'(byte_o), 32'd0);
    chk("rst_cnt",   byte_cnt, 32'd0);
    chk("rst_ovf",   32'(ovf), 32'd0);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_sig",   sig, 32'd0);

    // single sparse beat: lanes 0 and 15
    sdata = DATA_A; sstrb = 16'h8001; svalid = 1'b1;
    tick();
    idle_bus();
    chk("t1_lat1_valid", 32'(byte_valid), 32'd0);
    chk("t1_lat1_empty", 32'(empty), 32'd0);
    tick();
    chk("t1_b0_valid", 32'(byte_valid), 32'd1);
    chk("t1_b0",       32'(byte_o), 32'h00);
    tick();
    chk("t1_b1_valid", 32'(byte_valid), 32'd1);
    chk("t1_b1",       32'(byte_o), 32'h0F);
    tick();
    chk("t1_done_valid", 32'(byte_valid), 32'd0);
    chk("t1_cnt",        byte_cnt, 32'd2);
    chk("t1_empty",      32'(empty), 32'd1);

    // back-to-back full beats, no bubble
    sdata = DATA_A; sstrb = 16'hFFFF; svalid = 1'b1;
    tick();
    sdata = DATA_B;
    tick();
    idle_bus();
    for (int i = 0; i < 32; i++) begin
      chk("t2_valid", 32'(byte_valid), 32'd1);
      chk("t2_byte",  32'(byte_o), 32'(i));
      tick();
    end
    chk("t2_done_valid", 32'(byte_valid), 32'd0);
    chk("t2_cnt",        byte_cnt, 32'd34);
    chk("t2_empty",      32'(empty), 32'd1);

    // overflow: consumer stalled, 6 single-lane beats
    byte_ready = 1'b0;
    sstrb = 16'h0001; svalid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      sdata = 128'(k + 1);
      tick();
    end
    idle_bus();
    chk("t3_ovf",   32'(ovf), 32'd1);
    chk("t3_valid", 32'(byte_valid), 32'd1);
    chk("t3_hold0", 32'(byte_o), 32'h01);
    tick(); tick();
    chk("t3_hold1", 32'(byte_o), 32'h01);
    chk("t3_cnt_stall", byte_cnt, 32'd34);
    byte_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      chk("t3_valid_drain", 32'(byte_valid), 32'd1);
      chk("t3_byte", 32'(byte_o), 32'(k + 1));
      tick();
    end
    chk("t3_no6th", 32'(byte_valid), 32'd0);
    chk("t3_empty", 32'(empty), 32'd1);
    chk("t3_cnt",   byte_cnt, 32'd39);
    chk("t3_ovf_sticky", 32'(ovf), 32'd1);

    // disabled capture and zero-strobe beat
    do_reset();
    en = 1'b0; sdata = DATA_A; sstrb = 16'hFFFF; svalid = 1'b1;
    tick(); tick(); tick();
    en = 1'b1; sstrb = 16'h0000;
    tick(); tick(); tick();
    idle_bus();
    tick(); tick();
    chk("t4_valid", 32'(byte_valid), 32'd0);
    chk("t4_cnt",   byte_cnt, 32'd0);
    chk("t4_ovf",   32'(ovf), 32'd0);
    chk("t4_empty", 32'(empty), 32'd1);

    // reset mid-beat after 3 bytes
    sdata = DATA_A; sstrb = 16'hFFFF; svalid = 1'b1;
    tick();
    idle_bus();
    tick();
    tick(); tick(); tick();
    chk("t5_cnt3", byte_cnt, 32'd3);
    chk("t5_byte3", 32'(byte_o), 32'h03);
    rst_n = 1'b0;
    tick();
    chk("t5_rst_valid", 32'(byte_valid), 32'd0);
    chk("t5_rst_cnt",   byte_cnt, 32'd0);
    chk("t5_rst_empty", 32'(empty), 32'd1);
    chk("t5_rst_byte",  32'(byte_o), 32'd0);
    rst_n = 1'b1;
    tick(); tick(); tick();
    chk("t5_post_valid", 32'(byte_valid), 32'd0);
    chk("t5_post_empty", 32'(empty), 32'd1);

    // signature: bytes 01,02 then 01,01
    sdata = 128'h0201; sstrb = 16'h0003; svalid = 1'b1;
    tick();
    idle_bus();
    tick(); tick(); tick();
    chk("t6_cnt", byte_cnt, 32'd2);
    chk("t6_sig_a", sig, 32'h0000_0000);
    do_reset();
    sdata = 128'h0101; sstrb = 16'h0003; svalid = 1'b1;
    tick();
    idle_bus();
    tick(); tick(); tick();
`ifdef W_SERIALIZER_SIG_EN
    chk("t6_sig_b", sig, 32'h0000_0003);
`else
    chk("t6_sig_b", sig, 32'h0000_0000);
`endif
    chk("t6_empty", 32'(empty), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
